// File: rtl/dsp_addsub_seq.sv
// Sequential add/subtract: WIDTH-bit operands processed CHUNK bits per cycle through a registered carry.
// Optional signed-overflow and zero flags are built when DSP_ADDSUB_SEQ_FLAGS_EN is defined.
module dsp_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             carry_r;
  logic [WIDTH-1:0] result_r;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sum_c;
  logic             last;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == CW'(NCHUNK - 1));

  // b_c is already inverted for subtract; carry_r was preloaded with sub on accept
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_c = a_r[i*CHUNK +: CHUNK];
        b_c = b_r[i*CHUNK +: CHUNK];
      end
    end
    if (sub_r) b_c = ~b_c;
    sum_c = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sub_r    <= 1'b0;
      carry_r  <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            sub_r    <= sub;
            cnt      <= '0;
            carry_r  <= sub;
            result_r <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) result_r[i*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
          end
          carry_r <= sum_c[CHUNK];
          cnt     <= cnt + CW'(1);
          if (last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign carry_out = carry_r;

`ifdef DSP_ADDSUB_SEQ_FLAGS_EN
  logic ovf_r;
  logic zero_r;
  logic allz_r;

  // allz_r tracks whether every chunk finished so far was zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      allz_r <= 1'b0;
    end else if (accept) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      allz_r <= 1'b1;
    end else if (state == RUN) begin
      allz_r <= allz_r & (sum_c[CHUNK-1:0] == '0);
      if (last) begin
        zero_r <= allz_r & (sum_c[CHUNK-1:0] == '0);
        ovf_r  <= (a_c[CHUNK-1] == b_c[CHUNK-1]) & (sum_c[CHUNK-1] != a_c[CHUNK-1]);
      end
    end
  end

  assign overflow = ovf_r;
  assign zero     = zero_r;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_addsub_seq.sv
// Bench for dsp_addsub_seq: directed 32/8 vectors, hold and mid-run reset, then 16/16 streaming against a model.
module tb_dsp_addsub_seq;

`ifdef DSP_ADDSUB_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid0 = 0, in_ready0, sub0 = 0, out_valid0, out_ready0 = 0;
  logic [31:0] a0 = 0, b0 = 0, res0;
  logic        co0, ovf0, z0;

  logic        in_valid1 = 0, in_ready1, sub1 = 0, out_valid1, out_ready1 = 1;
  logic [15:0] a1 = 0, b1 = 0, res1;
  logic        co1, ovf1, z1;

  dsp_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(res0), .carry_out(co0), .overflow(ovf0), .zero(z0));

  dsp_addsub_seq #(.WIDTH(16), .CHUNK(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .result(res1), .carry_out(co1), .overflow(ovf1), .zero(z1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        co;
    logic        ovf;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ovf;
    logic        z;
  } exp16_t;

  task automatic op32(input vec_t v, input int hold, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, " in_ready idle"}, in_ready0, 1);
    in_valid0 = 1; a0 = v.a; b0 = v.b; sub0 = v.sub;
    @(posedge clk); #1;
    in_valid0 = 0; a0 = ~v.a; b0 = $urandom; sub0 = ~v.sub;
    chk({tag, " in_ready run"}, in_ready0, 0);
    cyc = 0;
    while (!out_valid0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " result"}, res0, v.res);
    chk({tag, " carry_out"}, co0, v.co);
    chk({tag, " overflow"}, ovf0, v.ovf & FLAGS);
    chk({tag, " zero"}, z0, v.z & FLAGS);
    chk({tag, " in_ready done"}, in_ready0, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, out_valid0, 1);
      chk({tag, " hold in_ready"}, in_ready0, 0);
      chk({tag, " hold result"}, {res0, co0, ovf0, z0}, {v.res, v.co, v.ovf & FLAGS, v.z & FLAGS});
    end
    out_ready0 = 1;
    @(posedge clk); #1;
    out_ready0 = 0;
    chk({tag, " out_valid after handshake"}, out_valid0, 0);
    chk({tag, " in_ready after handshake"}, in_ready0, 1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    #3;
    chk("reset in_ready", in_ready0, 1);
    chk("reset out_valid", out_valid0, 0);
    chk("reset outputs", {res0, co0, ovf0, z0}, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 6; i++) op32(vecs[i], 1, $sformatf("vec%0d", i));
    op32(vecs[6], 10, "equal_hold10");

    // reset during the second RUN cycle
    @(negedge clk);
    in_valid0 = 1; a0 = 32'h5; b0 = 32'h3; sub0 = 1;
    @(posedge clk); #1; in_valid0 = 0;
    @(posedge clk); #2;
    chk("midrun partial result", res0, 32'h2);
    rst_n = 0; #1;
    chk("midrun reset out_valid", out_valid0, 0);
    chk("midrun reset in_ready", in_ready0, 1);
    chk("midrun reset outputs", {res0, co0, ovf0, z0}, 0);
    @(negedge clk); rst_n = 1;
    op32('{32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0}, 1, "after_reset");

    // 16/16 streaming: in_valid held high, out_ready tied high
    begin
      exp16_t q[$];
      exp16_t e;
      logic [16:0] full;
      logic [15:0] bb;
      logic acc;
      int n_acc = 0, n_out = 0, cyc = 0, last_out = -1;
      in_valid1 = 1;
      a1 = 16'($urandom); b1 = 16'($urandom); sub1 = 1'($urandom);
      while (n_out < 1000 && cyc < 3300) begin
        @(negedge clk);
        cyc++;
        if (in_ready1 && out_valid1) chk("w16 ready/valid overlap", 1, 0);
        if (out_valid1) begin
          if (q.size() == 0) chk("w16 unexpected output", 1, 0);
          else begin
            e = q.pop_front();
            chk("w16 result/carry", {res1, co1}, {e.res, e.co});
            chk("w16 flags", {ovf1, z1}, {e.ovf & FLAGS, e.z & FLAGS});
          end
          if (last_out >= 0) chk("w16 interval", cyc - last_out, 3);
          last_out = cyc;
          n_out++;
        end
        acc = in_ready1;
        @(posedge clk); #1;
        if (acc && n_acc < 1000) begin
          bb   = sub1 ? ~b1 : b1;
          full = {1'b0, a1} + {1'b0, bb} + {16'b0, sub1};
          e.res = full[15:0];
          e.co  = full[16];
          e.ovf = (a1[15] == bb[15]) && (full[15] != a1[15]);
          e.z   = (full[15:0] == 16'h0);
          q.push_back(e);
          n_acc++;
          if (n_acc % 97 == 0) begin a1 = 16'h8000; b1 = 16'h8000; sub1 = 0; end
          else if (n_acc % 89 == 0) begin a1 = 16'h1234; b1 = 16'h1234; sub1 = 1; end
          else begin a1 = 16'($urandom); b1 = 16'($urandom); sub1 = 1'($urandom); end
          if (n_acc == 1000) in_valid1 = 0;
        end
      end
      chk("w16 outputs seen", n_out, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
